// File: rtl/yolo_pkg.sv
// Shared types and constants for the post-conv requantisation datapath.
// Saturation helpers live here so every lane clamps identically.
package yolo_pkg;

  localparam int PIN         = 8;
  localparam int PIN_LOG     = $clog2(PIN);
  localparam int ACC_W       = 32;
  localparam int SCALE_W     = 16;
  localparam int MAX_GROUPS  = 128;
  localparam int GRP_W       = $clog2(MAX_GROUPS);
  localparam int LEAKY_MUL   = 13;
  localparam int LEAKY_SHIFT = 7;
  localparam int PROD_W      = ACC_W + SCALE_W;
  // Headroom for the x13 leaky multiply plus the rounding increment.
  localparam int RND_W       = PROD_W + 5;
  localparam int SH_W        = 6;

  typedef logic signed [ACC_W-1:0]  acc_lane_t;
  typedef logic signed [7:0]        int8_lane_t;
  typedef logic        [SCALE_W-1:0] scale_lane_t;
  typedef logic signed [PROD_W-1:0] prod_lane_t;
  typedef logic signed [RND_W-1:0]  rnd_lane_t;

  function automatic acc_lane_t sat_acc(input logic signed [ACC_W:0] x);
    if (x[ACC_W] != x[ACC_W-1]) begin
      return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return x[ACC_W-1:0];
  endfunction

  function automatic int8_lane_t sat_int8(input rnd_lane_t x);
    if (x > rnd_lane_t'(127)) begin
      return 8'h7F;
    end
    if (x < rnd_lane_t'(-128)) begin
      return 8'h80;
    end
    return x[7:0];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantisation lane: bias+saturate, scale, leaky/rounding shift, int8 clamp.
// Each stage register only loads when its beat is valid, so data_out holds between beats.
module requant_lane
  import yolo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        s1_valid,
  input  logic        s2_valid,
  input  logic        s3_valid,
  input  logic        leaky_s2,
  input  logic [4:0]  shift_amt,
  input  acc_lane_t   acc,
  input  acc_lane_t   bias,
  input  scale_lane_t scale,
  output int8_lane_t  lane_out
);

  acc_lane_t   s_q, s_d;
  scale_lane_t scale_q, scale_d;
  prod_lane_t  p_q, p_d;
  rnd_lane_t   r_q, r_d;
  int8_lane_t  out_q, out_d;

  logic signed [ACC_W:0]  sum;
  logic signed [PROD_W:0] prod_full;
  rnd_lane_t              p_ext;
  rnd_lane_t              p_adj;
  rnd_lane_t              rnd_inc;
  logic [SH_W-1:0]        sh;

  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
    s_d     = s_q;
    scale_d = scale_q;
    if (in_valid) begin
      s_d     = sat_acc(sum);
      scale_d = scale;
    end

    // Scale is unsigned: zero-extend it before the signed multiply.
    prod_full = $signed({{(SCALE_W+1){s_q[ACC_W-1]}}, s_q}) *
                $signed({{ACC_W{1'b0}}, scale_q});
    p_d = p_q;
    if (s1_valid) begin
      p_d = prod_full[PROD_W-1:0];
    end

    p_ext = {{(RND_W-PROD_W){p_q[PROD_W-1]}}, p_q};
    p_adj = p_ext;
    sh    = {1'b0, shift_amt};
    if (leaky_s2 && p_q[PROD_W-1]) begin
      p_adj = p_ext * rnd_lane_t'(LEAKY_MUL);
      sh    = {1'b0, shift_amt} + SH_W'(LEAKY_SHIFT);
    end
    rnd_inc = '0;
    if (sh != '0) begin
      rnd_inc = rnd_lane_t'(1) <<< (sh - SH_W'(1));
    end
    r_d = r_q;
    if (s2_valid) begin
      r_d = (p_adj + rnd_inc) >>> sh;
    end

    out_d = out_q;
    if (s3_valid) begin
      out_d = sat_int8(r_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      scale_q <= '0;
      p_q     <= '0;
      r_q     <= '0;
      out_q   <= '0;
    end else begin
      s_q     <= s_d;
      scale_q <= scale_d;
      p_q     <= p_d;
      r_q     <= r_d;
      out_q   <= out_d;
    end
  end

  assign lane_out = out_q;

endmodule

// File: rtl/requant_leaky.sv
// Requantisation stage feeding maxPool: group counter, bias/scale table, valid pipe,
// and PIN parallel lanes with a fixed 4-cycle latency.
module requant_leaky
  import yolo_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              channels,
  input  logic [4:0]               shift_amt,
  input  logic                     leaky_en,
  input  logic                     cfg_wr_en,
  input  logic [GRP_W-1:0]         cfg_addr,
  input  logic [PIN*ACC_W-1:0]     cfg_bias,
  input  logic [PIN*SCALE_W-1:0]   cfg_scale,
  input  logic [PIN*ACC_W-1:0]     acc_in,
  input  logic                     acc_valid,
  output logic [PIN*8-1:0]         data_out,
  output logic                     valid_out
);

  logic [PIN*ACC_W-1:0]   bias_tbl_q  [MAX_GROUPS];
  logic [PIN*SCALE_W-1:0] scale_tbl_q [MAX_GROUPS];
  logic [PIN*ACC_W-1:0]   bias_row;
  logic [PIN*SCALE_W-1:0] scale_row;

  logic [GRP_W-1:0] g_q, g_d;
  logic [3:0]       vld_q, vld_d;
  logic [1:0]       leaky_q, leaky_d;
  logic [15:0]      num_groups;
  logic             grp_ok;

  int8_lane_t lane_out [PIN];

  always_comb begin
    num_groups = channels >> PIN_LOG;
    grp_ok     = (channels != '0) && (channels[PIN_LOG-1:0] == '0);
    g_d        = g_q;
    if (!grp_ok) begin
      g_d = '0;
    end else if (acc_valid) begin
      g_d = (16'(g_q) == num_groups - 16'd1) ? '0 : g_q + GRP_W'(1);
    end

    vld_d   = {vld_q[2:0], acc_valid};
    // Leaky select travels with its beat so a mid-stream toggle stays beat-accurate.
    leaky_d = leaky_q;
    if (acc_valid) begin
      leaky_d[0] = leaky_en;
    end
    if (vld_q[0]) begin
      leaky_d[1] = leaky_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      vld_q   <= '0;
      leaky_q <= '0;
    end else begin
      g_q     <= g_d;
      vld_q   <= vld_d;
      leaky_q <= leaky_d;
    end
  end

  // Table has no reset; reads are combinational so a same-cycle write returns the old entry.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      bias_tbl_q[cfg_addr]  <= cfg_bias;
      scale_tbl_q[cfg_addr] <= cfg_scale;
    end
  end

  assign bias_row  = bias_tbl_q[g_q];
  assign scale_row = scale_tbl_q[g_q];

  for (genvar i = 0; i < PIN; i++) begin : g_lane
    requant_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (acc_valid),
      .s1_valid  (vld_q[0]),
      .s2_valid  (vld_q[1]),
      .s3_valid  (vld_q[2]),
      .leaky_s2  (leaky_q[1]),
      .shift_amt (shift_amt),
      .acc       (acc_in[i*ACC_W +: ACC_W]),
      .bias      (bias_row[i*ACC_W +: ACC_W]),
      .scale     (scale_row[i*SCALE_W +: SCALE_W]),
      .lane_out  (lane_out[i])
    );
    assign data_out[i*8 +: 8] = lane_out[i];
  end

  assign valid_out = vld_q[3];

endmodule

// File: tb/tb_requant_leaky.sv
// Bench for requant_leaky: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_requant_leaky;
  import yolo_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic [15:0]            channels;
  logic [4:0]             shift_amt;
  logic                   leaky_en;
  logic                   cfg_wr_en;
  logic [GRP_W-1:0]       cfg_addr;
  logic [PIN*ACC_W-1:0]   cfg_bias;
  logic [PIN*SCALE_W-1:0] cfg_scale;
  logic [PIN*ACC_W-1:0]   acc_in;
  logic                   acc_valid;
  logic [PIN*8-1:0]       data_out;
  logic                   valid_out;

  requant_leaky dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .channels  (channels),
    .shift_amt (shift_amt),
    .leaky_en  (leaky_en),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_bias  (cfg_bias),
    .cfg_scale (cfg_scale),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam longint I32MAX = 64'sd2147483647;
  localparam longint I32MIN = -64'sd2147483648;

  logic signed [31:0] m_bias  [MAX_GROUPS][PIN];
  logic [15:0]        m_scale [MAX_GROUPS][PIN];
  int                 m_g;

  typedef struct {
    int unsigned due;
    logic [63:0] word;
  } exp_t;
  exp_t        exp_q[$];
  logic [63:0] last_word;

  typedef struct {
    logic signed [31:0] acc;
    logic signed [31:0] bias;
    logic [15:0]        scale;
    logic [4:0]         shift;
    logic               leaky;
    logic signed [7:0]  exp;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [7:0] ref_lane(input logic signed [31:0] acc, input logic signed [31:0] bias,
                                          input logic [15:0] sc, input int sh, input logic lk);
    longint s;
    longint p;
    int     shv;
    s = longint'(acc) + longint'(bias);
    if (s > I32MAX) s = I32MAX;
    if (s < I32MIN) s = I32MIN;
    p   = s * longint'(sc);
    shv = sh;
    if (lk && p < 0) begin
      p   = p * 13;
      shv = shv + 7;
    end
    if (shv > 0) p = (p + (longint'(1) <<< (shv - 1))) >>> shv;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p[7:0];
  endfunction

  function automatic logic [63:0] ref_word(input logic [255:0] a, input logic lk, input int g);
    logic [63:0] w;
    for (int i = 0; i < PIN; i++) begin
      w[i*8 +: 8] = ref_lane(a[i*32 +: 32], m_bias[g][i], m_scale[g][i], int'(shift_amt), lk);
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [255:0] a, input logic lk, input logic wr,
                               input logic [6:0] addr, input logic [255:0] b, input logic [127:0] s);
    exp_t e;
    @(posedge clk);
    #1;
    acc_valid = v;
    acc_in    = a;
    leaky_en  = lk;
    cfg_wr_en = wr;
    cfg_addr  = addr;
    cfg_bias  = b;
    cfg_scale = s;
    if (v) begin
      e.due  = cyc + 4;
      e.word = ref_word(a, lk, m_g);
      exp_q.push_back(e);
      if (channels != 0 && channels % 8 == 0) m_g = (m_g + 1) % int'(channels / 8);
      else m_g = 0;
    end
    if (wr) begin
      for (int i = 0; i < PIN; i++) begin
        m_bias[addr][i]  = b[i*32 +: 32];
        m_scale[addr][i] = s[i*16 +: 16];
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 7'd0, '0, '0);
  endtask

  task automatic writeGroup(input logic [6:0] addr, input logic [31:0] b, input logic [15:0] s);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, addr, {8{b}}, {8{s}});
  endtask

  task automatic beat(input logic [31:0] a, input logic lk);
    applyStimulus(1'b1, {8{a}}, lk, 1'b0, 7'd0, '0, '0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    acc_valid = 1'b0;
    cfg_wr_en = 1'b0;
    exp_q.delete();
    m_g       = 0;
    last_word = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitValid(input int unsigned k, output int lat);
    for (int i = 0; i < 10; i++) begin
      idle();
      @(negedge clk);
      if (valid_out) break;
    end
    lat = int'(cyc - k);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_valid", 64'(valid_out), 64'd0);
      checkOutput("rst_data", data_out, 64'd0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      checkOutput("sb_valid", 64'(valid_out), 64'd1);
      checkOutput("sb_data", data_out, exp_q[0].word);
      last_word = exp_q[0].word;
      void'(exp_q.pop_front());
    end else begin
      checkOutput("sb_idle_valid", 64'(valid_out), 64'd0);
      checkOutput("sb_hold", data_out, last_word);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int unsigned k;
    int          sh_list [3];
    int          sc_max  [3];
    int          acc_rng [3];
    logic [255:0] a;
    logic [255:0] b;
    logic [127:0] s;

    rst_n = 1'b1; channels = 16'd8; shift_amt = '0; leaky_en = 0; cfg_wr_en = 0;
    cfg_addr = '0; cfg_bias = '0; cfg_scale = '0; acc_in = '0; acc_valid = 0;
    last_word = '0; m_g = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_valid", 64'(valid_out), 64'd0);
    checkOutput("reset_data", data_out, 64'd0);

    vecs[0]  = '{32'sd100,      32'sd28,   16'd1,     5'd0,  1'b0, 8'sd127};
    vecs[1]  = '{-32'sd100,     32'sd0,    16'd1,     5'd0,  1'b1, -8'sd10};
    vecs[2]  = '{-32'sd100,     32'sd0,    16'd1,     5'd0,  1'b0, -8'sd100};
    vecs[3]  = '{32'sd10,       32'sd0,    16'd3,     5'd2,  1'b0, 8'sd8};
    vecs[4]  = '{-32'sd10,      32'sd0,    16'd3,     5'd2,  1'b0, -8'sd7};
    vecs[5]  = '{32'h7FFFFFF0,  32'h100,   16'd1,     5'd24, 1'b0, 8'sd127};
    vecs[6]  = '{32'h80000005,  -32'sd100, 16'd2,     5'd30, 1'b0, -8'sd4};
    vecs[7]  = '{32'sd6,        32'sd0,    16'd1,     5'd2,  1'b0, 8'sd2};
    vecs[8]  = '{-32'sd6,       32'sd0,    16'd1,     5'd2,  1'b0, -8'sd1};
    vecs[9]  = '{-32'sd1000,    32'sd0,    16'd1,     5'd1,  1'b1, -8'sd51};
    vecs[10] = '{32'sd50,       32'sd0,    16'd1,     5'd0,  1'b1, 8'sd50};
    vecs[11] = '{-32'sd200,     32'sd0,    16'd1,     5'd0,  1'b0, 8'h80};
    vecs[12] = '{32'sd40,       32'sd0,    16'hFFFF,  5'd16, 1'b0, 8'sd40};

    channels = 16'd8;
    for (int i = 0; i < 13; i++) begin
      shift_amt = vecs[i].shift;
      writeGroup(7'd0, vecs[i].bias, vecs[i].scale);
      beat(vecs[i].acc, vecs[i].leaky);
      k = cyc;
      waitValid(k, lat);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      checkOutput($sformatf("vec%0d_data", i), data_out, {8{vecs[i].exp}});
    end

    // Two groups back to back: counter wraps with no bubbles.
    doReset();
    channels = 16'd16; shift_amt = 5'd0;
    writeGroup(7'd0, 32'd0, 16'd1);
    writeGroup(7'd1, 32'd50, 16'd1);
    beat(32'd0, 1'b0);
    k = cyc;
    repeat (3) beat(32'd0, 1'b0);
    waitValid(k, lat);
    checkOutput("b2b_latency", 64'(lat), 64'd4);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("b2b%0d_valid", j), 64'(valid_out), 64'd1);
      checkOutput($sformatf("b2b%0d_data", j), data_out, (j % 2 == 1) ? {8{8'd50}} : 64'd0);
      if (j < 3) begin
        idle();
        @(negedge clk);
      end
    end

    // Reset in the middle of a burst drops in-flight beats and restarts at group 0.
    repeat (4) idle();
    repeat (3) beat(32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0; acc_valid = 1'b0;
    exp_q.delete(); m_g = 0; last_word = '0;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(valid_out), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    writeGroup(7'd0, 32'd0, 16'd1);
    writeGroup(7'd1, 32'd50, 16'd1);
    beat(32'd0, 1'b0);
    k = cyc;
    beat(32'd0, 1'b0);
    waitValid(k, lat);
    checkOutput("midrst_latency", 64'(lat), 64'd4);
    checkOutput("midrst_first_g0", data_out, 64'd0);
    idle();
    @(negedge clk);
    checkOutput("midrst_second_g1", data_out, {8{8'd50}});

    // Same-cycle table write and read of group 0 sees the old entry.
    doReset();
    channels = 16'd8; shift_amt = 5'd0;
    writeGroup(7'd0, 32'd0, 16'd1);
    applyStimulus(1'b1, {8{32'd5}}, 1'b0, 1'b1, 7'd0, {8{32'd100}}, {8{16'd1}});
    k = cyc;
    beat(32'd5, 1'b0);
    waitValid(k, lat);
    checkOutput("rdfirst_old", data_out, {8{8'd5}});
    idle();
    @(negedge clk);
    checkOutput("rdfirst_new", data_out, {8{8'd105}});

    // Degenerate channel count pins the counter to group 0.
    doReset();
    channels = 16'd0;
    writeGroup(7'd0, 32'd0, 16'd1);
    writeGroup(7'd1, 32'd50, 16'd1);
    beat(32'd7, 1'b0);
    k = cyc;
    repeat (2) beat(32'd7, 1'b0);
    waitValid(k, lat);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("chan0_%0d", j), data_out, {8{8'd7}});
      if (j < 2) begin
        idle();
        @(negedge clk);
      end
    end

    // Randomized traffic with gaps and per-beat leaky toggling.
    sh_list = '{0, 9, 20};
    sc_max  = '{3, 1023, 65535};
    acc_rng = '{200, 100000, 2000000};
    for (int ph = 0; ph < 3; ph++) begin
      doReset();
      channels  = 16'd32;
      shift_amt = 5'(sh_list[ph]);
      for (int gi = 0; gi < 4; gi++) begin
        for (int i = 0; i < PIN; i++) begin
          case ($urandom_range(0, 7))
            0:       b[i*32 +: 32] = 32'h7FFF_FF00;
            1:       b[i*32 +: 32] = 32'h8000_0100;
            default: b[i*32 +: 32] = 32'($urandom_range(0, 2 * acc_rng[ph])) - 32'(acc_rng[ph]);
          endcase
          s[i*16 +: 16] = 16'($urandom_range(0, sc_max[ph]));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'(gi), b, s);
      end
      for (int n = 0; n < 150; n++) begin
        for (int i = 0; i < PIN; i++) begin
          if ($urandom_range(0, 7) == 0) a[i*32 +: 32] = $urandom;
          else a[i*32 +: 32] = 32'($urandom_range(0, 2 * acc_rng[ph])) - 32'(acc_rng[ph]);
        end
        applyStimulus(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), 1'b0, 7'd0, '0, '0);
      end
      repeat (8) idle();
    end

    repeat (2) idle();
    checkOutput("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
